// File: rtl/if_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package if_icache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RESP} icache_state_t;

  localparam int ICACHE_LINE_BITS   = 256;
  localparam int ICACHE_OFFSET_BITS = 5;

  // Word w of a line lives at bits [32w+31:32w].
  function automatic logic [31:0] icache_word(input logic [ICACHE_LINE_BITS-1:0] line,
                                              input logic [2:0] w);
    return line[w*32 +: 32];
  endfunction
endpackage

// File: rtl/if_icache_if.sv
// Fetch-side and line-fill-side signals of the instruction cache.
interface if_icache_if;
  import if_icache_pkg::*;

  logic                        icache_read_i;
  logic [31:0]                 icache_addr_i;
  logic                        icache_flush_i;
  logic [31:0]                 icache_rdata_o;
  logic                        icache_resp_o;
  logic                        pmem_read_o;
  logic [31:0]                 pmem_address_o;
  logic [ICACHE_LINE_BITS-1:0] pmem_rdata_i;
  logic                        pmem_resp_i;

  // master: fetch stage plus memory arbiter; slave: the cache
  modport master (
    output icache_read_i, icache_addr_i, icache_flush_i, pmem_rdata_i, pmem_resp_i,
    input  icache_rdata_o, icache_resp_o, pmem_read_o, pmem_address_o
  );
  modport slave (
    input  icache_read_i, icache_addr_i, icache_flush_i, pmem_rdata_i, pmem_resp_i,
    output icache_rdata_o, icache_resp_o, pmem_read_o, pmem_address_o
  );
endinterface

// File: rtl/icache_array.sv
// Flop array: asynchronous read, synchronous write, synchronous clear of all rows.
module icache_array #(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  localparam int DEPTH = 2**ADDR_BITS;

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // clear beats write so a flush landing on a fill leaves the row invalid
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    always_ff @(posedge clk) begin
      if (clr)                                 mem[i] <= '0;
      else if (we && waddr == ADDR_BITS'(i))   mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_icache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, one 256-bit line fill per miss.
module if_icache
  import if_icache_pkg::*;
#(
  parameter  int S_INDEX = 4,
  localparam int S_TAG   = 32 - ICACHE_OFFSET_BITS - S_INDEX
) (
  input logic         clk,
  input logic         rst,
  if_icache_if.slave  bus
);
  icache_state_t               state;
  logic [31:2]                 addr_q;
  logic [31:0]                 word_q;
  logic                        flush_pend;

  logic [S_INDEX-1:0]          idx_rd, idx_wr;
  logic [S_TAG-1:0]            tag_in, tag_fill, tag_rd;
  logic                        valid_rd, hit, fill_done, valid_clr;
  logic [ICACHE_LINE_BITS-1:0] line_rd;
  logic                        unused_addr_lsb;

  assign idx_rd   = bus.icache_addr_i[ICACHE_OFFSET_BITS +: S_INDEX];
  assign tag_in   = bus.icache_addr_i[31 -: S_TAG];
  assign idx_wr   = addr_q[ICACHE_OFFSET_BITS +: S_INDEX];
  assign tag_fill = addr_q[31 -: S_TAG];
  assign unused_addr_lsb = ^bus.icache_addr_i[1:0];

  assign hit       = (state == IDLE) && bus.icache_read_i && valid_rd && (tag_rd == tag_in);
  assign fill_done = (state == FILL) && bus.pmem_resp_i;
  // a flush seen during FILL is deferred to fill completion so the new line stays invalid
  assign valid_clr = rst
                   | (bus.icache_flush_i && state != FILL)
                   | (fill_done && (flush_pend || bus.icache_flush_i));

  icache_array #(.WIDTH(1), .ADDR_BITS(S_INDEX)) u_valid (
    .clk, .clr(valid_clr), .we(fill_done), .waddr(idx_wr), .wdata(1'b1),
    .raddr(idx_rd), .rdata(valid_rd)
  );

  icache_array #(.WIDTH(S_TAG), .ADDR_BITS(S_INDEX)) u_tag (
    .clk, .clr(1'b0), .we(fill_done), .waddr(idx_wr), .wdata(tag_fill),
    .raddr(idx_rd), .rdata(tag_rd)
  );

  icache_array #(.WIDTH(ICACHE_LINE_BITS), .ADDR_BITS(S_INDEX)) u_data (
    .clk, .clr(1'b0), .we(fill_done), .waddr(idx_wr), .wdata(bus.pmem_rdata_i),
    .raddr(idx_rd), .rdata(line_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.icache_read_i && !hit) begin
          state  <= FILL;
          addr_q <= bus.icache_addr_i[31:2];
        end
        FILL: begin
          if (bus.icache_flush_i) flush_pend <= 1'b1;
          if (bus.pmem_resp_i) begin
            word_q     <= icache_word(bus.pmem_rdata_i, addr_q[4:2]);
            flush_pend <= 1'b0;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.icache_resp_o  = hit || (state == RESP);
  assign bus.icache_rdata_o = hit             ? icache_word(line_rd, bus.icache_addr_i[4:2]) :
                              (state == RESP) ? word_q : '0;
  assign bus.pmem_read_o    = (state == FILL);
  assign bus.pmem_address_o = (state == FILL) ? {addr_q[31:5], 5'b0} : '0;
endmodule

// File: tb/tb_if_icache.sv
// Directed bench for if_icache: misses, hits, conflicts, flushes, reset mid-fill, back-to-back.
module tb_if_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [255:0] line0, line2, line8, line10, line18, line1a, line1c;

  if_icache_if bus();

  if_icache #(.S_INDEX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  // Full miss sequence for address a: miss, FILL (lat extra cycles), pmem_resp, one RESP cycle.
  // Returns with the DUT in RESP; the caller drives the next cycle.
  task automatic miss_fill(input logic [31:0] a, input logic [255:0] line,
                           input logic [31:0] exp, input int lat, input string nm);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    @(negedge clk); bus.icache_read_i = 1'b1; bus.icache_addr_i = a; bus.icache_flush_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL %s_miss resp got %0b want 0", nm, bus.icache_resp_o); end
    @(negedge clk); #1;
    n_chk++; if (bus.pmem_read_o !== 1'b1) begin n_fail++; $display("FAIL %s_pmem_read got %0b want 1", nm, bus.pmem_read_o); end
    n_chk++; if (bus.pmem_address_o !== la) begin n_fail++; $display("FAIL %s_pmem_addr got %h want %h", nm, bus.pmem_address_o, la); end
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL %s_fill_resp got %0b want 0", nm, bus.icache_resp_o); end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      n_chk++; if (bus.pmem_read_o !== 1'b1 || bus.pmem_address_o !== la) begin
        n_fail++; $display("FAIL %s_hold read %0b addr %h want 1 %h", nm, bus.pmem_read_o, bus.pmem_address_o, la); end
    end
    @(negedge clk); bus.pmem_rdata_i = line; bus.pmem_resp_i = 1'b1; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL %s_early_resp got %0b want 0", nm, bus.icache_resp_o); end
    @(negedge clk); bus.pmem_resp_i = 1'b0; bus.pmem_rdata_i = '0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1) begin n_fail++; $display("FAIL %s_resp got %0b want 1", nm, bus.icache_resp_o); end
    n_chk++; if (bus.icache_rdata_o !== exp) begin n_fail++; $display("FAIL %s_rdata got %h want %h", nm, bus.icache_rdata_o, exp); end
    n_chk++; if (bus.pmem_read_o !== 1'b0) begin n_fail++; $display("FAIL %s_pmem_done got %0b want 0", nm, bus.pmem_read_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp got %0b want 0", bus.icache_resp_o); end
    n_chk++; if (bus.icache_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.icache_rdata_o); end
    n_chk++; if (bus.pmem_read_o !== 1'b0) begin n_fail++; $display("FAIL rst_pmem_read got %0b want 0", bus.pmem_read_o); end
    n_chk++; if (bus.pmem_address_o !== 32'h0) begin n_fail++; $display("FAIL rst_pmem_addr got %h want 0", bus.pmem_address_o); end
  endtask

  task automatic test_cold_miss();
    miss_fill(32'h44, line0, 32'h00A00093, 2, "cold");
    @(negedge clk); bus.icache_read_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL cold_one_cycle resp got %0b want 0", bus.icache_resp_o); end
    n_chk++; if (bus.icache_rdata_o !== 32'h0) begin n_fail++; $display("FAIL cold_rdata_idle got %h want 0", bus.icache_rdata_o); end
  endtask

  task automatic test_hit();
    @(negedge clk); bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h40; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h40000000) begin
      n_fail++; $display("FAIL hit_w0 resp %0b data %h want 1 40000000", bus.icache_resp_o, bus.icache_rdata_o); end
    n_chk++; if (bus.pmem_read_o !== 1'b0) begin n_fail++; $display("FAIL hit_no_pmem got %0b want 0", bus.pmem_read_o); end
    @(negedge clk); bus.icache_addr_i = 32'h5C; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h40000007) begin
      n_fail++; $display("FAIL hit_w7 resp %0b data %h want 1 40000007", bus.icache_resp_o, bus.icache_rdata_o); end
    @(negedge clk); bus.icache_addr_i = 32'h5F; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h40000007) begin
      n_fail++; $display("FAIL hit_lsb_ignored resp %0b data %h want 1 40000007", bus.icache_resp_o, bus.icache_rdata_o); end
    @(negedge clk); bus.icache_addr_i = 32'h48; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h40000002) begin
      n_fail++; $display("FAIL hit_w2 resp %0b data %h want 1 40000002", bus.icache_resp_o, bus.icache_rdata_o); end
    @(negedge clk); bus.icache_read_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0 || bus.pmem_read_o !== 1'b0) begin
      n_fail++; $display("FAIL hit_idle resp %0b pmem %0b want 0 0", bus.icache_resp_o, bus.pmem_read_o); end
  endtask

  task automatic test_conflict();
    miss_fill(32'h248, line2, 32'h24000002, 0, "conf_evict");
    miss_fill(32'h40, line0, 32'h40000000, 1, "conf_reread");
    @(negedge clk); bus.icache_read_i = 1'b0;
  endtask

  task automatic test_flush();
    // flush in IDLE while hitting: hit still served, line gone afterwards
    @(negedge clk); bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h44; bus.icache_flush_i = 1'b1; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h00A00093) begin
      n_fail++; $display("FAIL flush_hit resp %0b data %h want 1 00a00093", bus.icache_resp_o, bus.icache_rdata_o); end
    miss_fill(32'h44, line0, 32'h00A00093, 0, "flush_idle");
    // flush pulse during FILL of 0x84
    @(negedge clk); bus.icache_addr_i = 32'h84; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL ffill_miss got %0b want 0", bus.icache_resp_o); end
    @(negedge clk); #1;
    n_chk++; if (bus.pmem_read_o !== 1'b1 || bus.pmem_address_o !== 32'h80) begin
      n_fail++; $display("FAIL ffill_req read %0b addr %h want 1 00000080", bus.pmem_read_o, bus.pmem_address_o); end
    bus.icache_flush_i = 1'b1;
    @(negedge clk); bus.icache_flush_i = 1'b0; #1;
    n_chk++; if (bus.pmem_read_o !== 1'b1) begin n_fail++; $display("FAIL ffill_hold got %0b want 1", bus.pmem_read_o); end
    @(negedge clk); bus.pmem_rdata_i = line8; bus.pmem_resp_i = 1'b1; #1;
    @(negedge clk); bus.pmem_resp_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h80000001) begin
      n_fail++; $display("FAIL ffill_resp resp %0b data %h want 1 80000001", bus.icache_resp_o, bus.icache_rdata_o); end
    miss_fill(32'h80, line8, 32'h80000000, 0, "ffill_reread");
    miss_fill(32'h44, line0, 32'h00A00093, 0, "ffill_other");
    @(negedge clk); bus.icache_read_i = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h10C; #1;
    @(negedge clk); #1;
    n_chk++; if (bus.pmem_read_o !== 1'b1 || bus.pmem_address_o !== 32'h100) begin
      n_fail++; $display("FAIL rmf_req read %0b addr %h want 1 00000100", bus.pmem_read_o, bus.pmem_address_o); end
    rst = 1'b1; bus.icache_read_i = 1'b0;
    @(negedge clk); rst = 1'b0; bus.pmem_rdata_i = line10; bus.pmem_resp_i = 1'b1; #1;
    n_chk++; if (bus.pmem_read_o !== 1'b0 || bus.pmem_address_o !== 32'h0) begin
      n_fail++; $display("FAIL rmf_pmem read %0b addr %h want 0 0", bus.pmem_read_o, bus.pmem_address_o); end
    n_chk++; if (bus.icache_resp_o !== 1'b0 || bus.icache_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rmf_resp resp %0b data %h want 0 0", bus.icache_resp_o, bus.icache_rdata_o); end
    @(negedge clk); bus.pmem_resp_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0 || bus.pmem_read_o !== 1'b0) begin
      n_fail++; $display("FAIL rmf_stray resp %0b pmem %0b want 0 0", bus.icache_resp_o, bus.pmem_read_o); end
    miss_fill(32'h10C, line10, 32'h10000003, 1, "rmf_reread");
    miss_fill(32'h80, line8, 32'h80000000, 0, "rmf_validclr");
    @(negedge clk); bus.icache_read_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    miss_fill(32'h180, line18, 32'h18000000, 0, "b2b_first");
    @(negedge clk); bus.icache_addr_i = 32'h184; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h18000001) begin
      n_fail++; $display("FAIL b2b_next resp %0b data %h want 1 18000001", bus.icache_resp_o, bus.icache_rdata_o); end
    @(negedge clk); bus.icache_addr_i = 32'h188; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b1 || bus.icache_rdata_o !== 32'h18000002) begin
      n_fail++; $display("FAIL b2b_next2 resp %0b data %h want 1 18000002", bus.icache_resp_o, bus.icache_rdata_o); end
    miss_fill(32'h1A8, line1a, 32'h1A000002, 0, "b2b_miss_a");
    miss_fill(32'h1CC, line1c, 32'h1C000003, 0, "b2b_miss_b");
    @(negedge clk); bus.icache_read_i = 1'b0; #1;
    n_chk++; if (bus.icache_resp_o !== 1'b0) begin n_fail++; $display("FAIL b2b_single resp got %0b want 0", bus.icache_resp_o); end
  endtask

  initial begin
    bus.icache_read_i  = 1'b0;
    bus.icache_addr_i  = '0;
    bus.icache_flush_i = 1'b0;
    bus.pmem_rdata_i   = '0;
    bus.pmem_resp_i    = 1'b0;
    line0  = mk_line(32'h40000000);
    line0[63:32] = 32'h00A00093;
    line2  = mk_line(32'h24000000);
    line8  = mk_line(32'h80000000);
    line10 = mk_line(32'h10000000);
    line18 = mk_line(32'h18000000);
    line1a = mk_line(32'h1A000000);
    line1c = mk_line(32'h1C000000);

    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
